// File: rtl/riscv_immenc.sv
// Two-stage elastic immediate encoder: S1 registers the request and its range/alignment
// verdict, S2 scatters the immediate into the instruction word and holds the result.
module riscv_immenc #(
  parameter int BW_DATA = 32,
  parameter int BW_CTRL = 3,
  parameter int BW_CNT  = 16
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [BW_DATA-1:0] i_imm,
  input  logic [BW_CTRL-1:0] i_imm_src,
  input  logic [BW_DATA-1:0] i_instr_base,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [BW_DATA-1:0] o_instr,
  output logic               o_err,
  output logic [1:0]         o_err_code,
  output logic [BW_CNT-1:0]  o_cnt_ok,
  output logic [BW_CNT-1:0]  o_cnt_err
);

  localparam logic [BW_CTRL-1:0] INSTR_I_TYPE = 3'd0;
  localparam logic [BW_CTRL-1:0] INSTR_S_TYPE = 3'd1;
  localparam logic [BW_CTRL-1:0] INSTR_B_TYPE = 3'd2;
  localparam logic [BW_CTRL-1:0] INSTR_U_TYPE = 3'd3;
  localparam logic [BW_CTRL-1:0] INSTR_J_TYPE = 3'd4;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_FMT   = 2'd3;

  // Range is tested before alignment, so an odd out-of-range value reports ERR_RANGE.
  function automatic logic [1:0] check_imm(input logic [BW_DATA-1:0] imm,
                                           input logic [BW_CTRL-1:0] src);
    logic signed [BW_DATA-1:0] v;
    logic [1:0]                code;
    v    = $signed(imm);
    code = ERR_NONE;
    case (src)
      INSTR_I_TYPE, INSTR_S_TYPE: begin
        if (v < -32'sd2048 || v > 32'sd2047) code = ERR_RANGE;
        else                                 code = ERR_NONE;
      end
      INSTR_B_TYPE: begin
        if (v < -32'sd4096 || v > 32'sd4094) code = ERR_RANGE;
        else if (imm[0])                     code = ERR_ALIGN;
        else                                 code = ERR_NONE;
      end
      INSTR_J_TYPE: begin
        if (v < -32'sd1048576 || v > 32'sd1048574) code = ERR_RANGE;
        else if (imm[0])                           code = ERR_ALIGN;
        else                                       code = ERR_NONE;
      end
      INSTR_U_TYPE: begin
        if (imm[11:0] != 12'd0) code = ERR_ALIGN;
        else                    code = ERR_NONE;
      end
      default: code = ERR_FMT;
    endcase
    return code;
  endfunction

  // Base fields outside the immediate positions pass through untouched.
  function automatic logic [BW_DATA-1:0] pack_imm(input logic [BW_DATA-1:0] imm,
                                                  input logic [BW_CTRL-1:0] src,
                                                  input logic [BW_DATA-1:0] base);
    logic [BW_DATA-1:0] w;
    w = base;
    case (src)
      INSTR_I_TYPE: w = {imm[11:0], base[19:0]};
      INSTR_S_TYPE: w = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
      INSTR_B_TYPE: w = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
      INSTR_U_TYPE: w = {imm[31:12], base[11:0]};
      INSTR_J_TYPE: w = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
      default:      w = base;
    endcase
    return w;
  endfunction

  logic               s1_valid_q, s1_valid_d;
  logic [BW_DATA-1:0] s1_imm_q, s1_imm_d;
  logic [BW_CTRL-1:0] s1_src_q, s1_src_d;
  logic [BW_DATA-1:0] s1_base_q, s1_base_d;
  logic [1:0]         s1_code_q, s1_code_d;

  logic               s2_valid_q, s2_valid_d;
  logic [BW_DATA-1:0] s2_instr_q, s2_instr_d;
  logic               s2_err_q, s2_err_d;
  logic [1:0]         s2_code_q, s2_code_d;

  logic [BW_CNT-1:0]  cnt_ok_q, cnt_ok_d;
  logic [BW_CNT-1:0]  cnt_err_q, cnt_err_d;

  logic s1_ready_s, s2_ready_s, in_fire_s, out_fire_s;

  assign s2_ready_s = !s2_valid_q || i_ready;
  assign s1_ready_s = !s1_valid_q || s2_ready_s;
  assign in_fire_s  = i_valid && s1_ready_s;
  assign out_fire_s = s2_valid_q && i_ready;

  assign o_ready    = s1_ready_s;
  assign o_valid    = s2_valid_q;
  assign o_instr    = s2_instr_q;
  assign o_err      = s2_err_q;
  assign o_err_code = s2_code_q;
  assign o_cnt_ok   = cnt_ok_q;
  assign o_cnt_err  = cnt_err_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_imm_d   = s1_imm_q;
    s1_src_d   = s1_src_q;
    s1_base_d  = s1_base_q;
    s1_code_d  = s1_code_q;
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    s2_code_d  = s2_code_q;
    cnt_ok_d   = cnt_ok_q;
    cnt_err_d  = cnt_err_q;

    if (s1_ready_s) begin
      s1_valid_d = in_fire_s;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (in_fire_s) begin
      s1_imm_d  = i_imm;
      s1_src_d  = i_imm_src;
      s1_base_d = i_instr_base;
      s1_code_d = check_imm(i_imm, i_imm_src);
    end else begin
      s1_code_d = s1_code_q;
    end

    // S2 only reloads when it can advance, so a stalled result holds its value.
    if (s2_ready_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_err_d   = (s1_code_q != ERR_NONE);
        s2_code_d  = s1_code_q;
        s2_instr_d = (s1_code_q == ERR_NONE) ? pack_imm(s1_imm_q, s1_src_q, s1_base_q)
                                             : s1_base_q;
      end else begin
        s2_err_d = s2_err_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end

    if (out_fire_s) begin
      if (s2_err_q) cnt_err_d = cnt_err_q + 16'd1;
      else          cnt_ok_d  = cnt_ok_q + 16'd1;
    end else begin
      cnt_ok_d = cnt_ok_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_valid_q <= 1'b0;
      s1_imm_q   <= 32'd0;
      s1_src_q   <= 3'd0;
      s1_base_q  <= 32'd0;
      s1_code_q  <= 2'd0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= 32'd0;
      s2_err_q   <= 1'b0;
      s2_code_q  <= 2'd0;
      cnt_ok_q   <= 16'd0;
      cnt_err_q  <= 16'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_imm_q   <= s1_imm_d;
      s1_src_q   <= s1_src_d;
      s1_base_q  <= s1_base_d;
      s1_code_q  <= s1_code_d;
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
      s2_code_q  <= s2_code_d;
      cnt_ok_q   <= cnt_ok_d;
      cnt_err_q  <= cnt_err_d;
    end
  end

endmodule

// File: tb/tb_riscv_immenc.sv
// Directed and randomised bench for riscv_immenc with a queue scoreboard and
// an independent bit-map reference model.
module tb_riscv_immenc;

  localparam logic [2:0] F_I = 3'd0, F_S = 3'd1, F_B = 3'd2, F_U = 3'd3, F_J = 3'd4, F_BAD = 3'd7;

  logic        i_clk = 1'b0, i_rstn = 1'b0, i_valid = 1'b0, i_ready = 1'b1;
  logic [31:0] i_imm = 32'd0, i_instr_base = 32'd0;
  logic [2:0]  i_imm_src = 3'd0;
  logic        o_ready, o_valid, o_err;
  logic [31:0] o_instr;
  logic [1:0]  o_err_code;
  logic [15:0] o_cnt_ok, o_cnt_err;

  int errors = 0;
  int checks = 0;
  logic [33:0] exp_q[$];
  bit rand_done;

  always #5 i_clk = ~i_clk;

  riscv_immenc dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(o_ready),
    .i_imm(i_imm), .i_imm_src(i_imm_src), .i_instr_base(i_instr_base),
    .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr), .o_err(o_err),
    .o_err_code(o_err_code), .o_cnt_ok(o_cnt_ok), .o_cnt_err(o_cnt_err)
  );

  // Which immediate bit lands in instruction bit b (-1 keeps the base bit).
  function automatic int imm_index(input logic [2:0] src, input int b);
    int r;
    r = -1;
    case (src)
      F_I: if (b >= 20) r = b - 20;
      F_S: if (b >= 25) r = b - 20; else if (b >= 7 && b <= 11) r = b - 7;
      F_B: if (b == 31) r = 12; else if (b >= 25) r = b - 20;
           else if (b >= 8 && b <= 11) r = b - 7; else if (b == 7) r = 11;
      F_U: if (b >= 12) r = b;
      F_J: if (b == 31) r = 20; else if (b >= 21) r = b - 20;
           else if (b == 20) r = 11; else if (b >= 12) r = b;
      default: r = -1;
    endcase
    return r;
  endfunction

  function automatic logic [33:0] model(input logic [31:0] imm, input logic [2:0] src,
                                        input logic [31:0] base);
    longint v;
    int idx;
    logic [1:0] code;
    logic [31:0] w;
    v = longint'($signed(imm));
    code = 2'd0;
    case (src)
      F_I, F_S: if (v < -2048 || v > 2047) code = 2'd1;
      F_B: if (v < -4096 || v > 4094) code = 2'd1; else if ((v & 64'd1) != 0) code = 2'd2;
      F_J: if (v < -1048576 || v > 1048574) code = 2'd1; else if ((v & 64'd1) != 0) code = 2'd2;
      F_U: if ((v & 64'hFFF) != 0) code = 2'd2;
      default: code = 2'd3;
    endcase
    w = base;
    if (code == 2'd0) begin
      for (int b = 0; b < 32; b++) begin
        idx = imm_index(src, b);
        if (idx >= 0) w[b] = imm[idx];
      end
    end
    return {code, w};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on each output handshake, and hold-check across stalls.
  logic        stall_q = 1'b0;
  logic [34:0] held_q = 35'd0;
  always @(negedge i_clk) begin
    logic [33:0] e;
    if (!i_rstn) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        checks++;
        assert (o_valid === 1'b1 && {o_err, o_err_code, o_instr} === held_q) else begin
          errors++;
          $error("FAIL stall_hold: observed v=%b %h expected v=1 %h", o_valid,
                 {o_err, o_err_code, o_instr}, held_q);
        end
      end
      if (o_valid && i_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $error("FAIL sb_extra: observed unexpected result %h expected none", o_instr);
        end else begin
          e = exp_q.pop_front();
          assert ({o_err, o_err_code, o_instr} === {(e[33:32] != 2'd0), e[33:32], e[31:0]}) else begin
            errors++;
            $error("FAIL sb_result: observed err=%b code=%0d instr=%h expected code=%0d instr=%h",
                   o_err, o_err_code, o_instr, e[33:32], e[31:0]);
          end
        end
      end
      stall_q <= o_valid && !i_ready;
      held_q  <= {o_err, o_err_code, o_instr};
    end
  end

  task automatic send(input logic [31:0] imm, input logic [2:0] src, input logic [31:0] base);
    bit acc;
    acc = 1'b0;
    i_valid = 1'b1; i_imm = imm; i_imm_src = src; i_instr_base = base;
    for (int n = 0; n < 60 && !acc; n++) begin
      @(negedge i_clk);
      acc = o_ready;
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL accept_timeout: observed o_ready=0 expected 1");
    end
    if (acc) exp_q.push_back(model(imm, src, base));
  endtask

  task automatic send_chk(input string tag, input logic [31:0] imm, input logic [2:0] src,
                          input logic [31:0] base, input logic [31:0] ei, input logic [1:0] ec);
    int n;
    send(imm, src, base);
    n = 0;
    do begin @(negedge i_clk); n++; end while (!o_valid && n < 10);
    chk(tag, {29'd0, o_valid, o_err, o_err_code, o_instr}, {29'd0, 1'b1, (ec != 2'd0), ec, ei});
    @(posedge i_clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    i_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin @(negedge i_clk); n++; end
    chk("drain", 64'(exp_q.size()), 64'd0);
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    i_rstn = 1'b0;
    #3;
    exp_q.delete();
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
  endtask

  initial begin
    #12;
    chk("rst_outputs", {28'd0, o_valid, o_err, o_err_code, o_instr}, 64'd0);
    chk("rst_counters", {32'd0, o_cnt_ok, o_cnt_err}, 64'd0);
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    @(negedge i_clk);
    chk("rst_ready", 64'(o_ready), 64'd1);
    @(posedge i_clk); #1;

    // Latency: accepted at edge N, visible after edge N+1
    send(32'hFFFF_FFFF, F_I, 32'h0000_0093);
    @(negedge i_clk);
    chk("lat_n", 64'(o_valid), 64'd0);
    @(negedge i_clk);
    chk("lat_n1", {31'd0, o_valid, o_instr}, {31'd0, 1'b1, 32'hFFF0_0093});
    @(posedge i_clk); #1;

    send_chk("s_type", 32'd8, F_S, 32'h0020_A023, 32'h0020_A423, 2'd0);
    send_chk("b_type", -32'sd4, F_B, 32'h0000_0063, 32'hFE00_0EE3, 2'd0);
    send_chk("j_type", 32'h800, F_J, 32'h0000_00EF, 32'h0010_00EF, 2'd0);
    send_chk("u_type", 32'h1234_5000, F_U, 32'h0000_0037, 32'h1234_5037, 2'd0);
    send_chk("b_misalign", 32'd3, F_B, 32'h0000_0063, 32'h0000_0063, 2'd2);
    send_chk("i_range", 32'd2048, F_I, 32'h0000_0093, 32'h0000_0093, 2'd1);
    send_chk("bad_fmt", 32'd4, F_BAD, 32'h1234_5678, 32'h1234_5678, 2'd3);
    @(negedge i_clk);
    chk("cnt_after_err", {32'd0, o_cnt_ok, o_cnt_err}, {32'd0, 16'd5, 16'd3});
    @(posedge i_clk); #1;

    // Range/alignment boundaries, streamed back to back
    send(32'd2047, F_I, 32'h13);         send(-32'sd2048, F_S, 32'h23);
    send(-32'sd2049, F_I, 32'h13);       send(32'd4094, F_B, 32'h63);
    send(32'd4095, F_B, 32'h63);         send(-32'sd4096, F_B, 32'h63);
    send(-32'sd4098, F_B, 32'h63);       send(32'd1048574, F_J, 32'h6F);
    send(32'd1048575, F_J, 32'h6F);      send(-32'sd1048576, F_J, 32'h6F);
    send(32'd1048576, F_J, 32'h6F);      send(32'hFFFF_F000, F_U, 32'h37);
    send(32'h0000_0001, F_U, 32'h37);    send(32'd5, 3'd5, 32'h37);
    drain();

    // Random requests under random backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          logic [31:0] r;
          r = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($signed(12'($urandom())) <<< 1);
          send(r, 3'($urandom_range(0, 7)), $urandom());
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge i_clk); #1;
          i_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();

    // Reset with two entries in flight
    i_ready = 1'b0;
    send(32'd16, F_I, 32'h13);
    send(32'd32, F_I, 32'h13);
    #2;
    i_rstn = 1'b0;
    #1;
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_cnt", {32'd0, o_cnt_ok, o_cnt_err}, 64'd0);
    exp_q.delete();
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    send_chk("post_rst", 32'h800, F_J, 32'h0000_00EF, 32'h0010_00EF, 2'd0);

    // Backpressure: two buffered, then o_ready low until downstream drains
    do_reset();
    i_ready = 1'b0;
    send(32'd100, F_I, 32'h13);
    send(-32'sd8, F_S, 32'h23);
    @(negedge i_clk);
    chk("bp_full", {62'd0, o_ready, o_valid}, {62'd0, 1'b0, 1'b1});
    @(posedge i_clk); #1;
    fork
      begin
        send(32'd64, F_B, 32'h63);
        send(32'h000F_F000, F_U, 32'h37);
        send(-32'sd2, F_J, 32'h6F);
      end
      begin
        repeat (2) @(posedge i_clk);
        #1 i_ready = 1'b1;
      end
    join
    drain();
    @(negedge i_clk);
    chk("bp_counts", {32'd0, o_cnt_ok, o_cnt_err}, {32'd0, 16'd5, 16'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_immenc.md
# riscv_immenc

Pipelined immediate encoder for the RISC-V core's program/test infrastructure, the inverse of the immediate-extension path. It takes a signed 32-bit immediate, an immediate-format code and a base instruction word, then scatters the immediate into the format's instruction bit positions. It checks range and alignment, and flags failures. It sits between the assembler/loader front end and instruction-memory write logic, behind a valid/ready handshake on both sides.

## Interface
- BW_DATA, 32, immediate and instruction width
- BW_CTRL, 3, immediate-format code width; codes are the `INSTR_I/S/B/U/J_TYPE` macros from riscv_configs.v
- BW_CNT, 16, width of the encoded/error event counters
- i_clk  input  1  clock, rising edge
- i_rstn  input  1  asynchronous active-low reset
- i_valid  input  1  input request valid
- o_ready  output  1  encoder can accept input this cycle
- i_imm  input  BW_DATA  signed immediate value (two's complement)
- i_imm_src  input  BW_CTRL  immediate format code
- i_instr_base  input  BW_DATA  instruction with opcode/rd/rs1/rs2/funct fields; immediate bit positions ignored
- o_valid  output  1  encoded result valid
- i_ready  input  1  downstream accepts result
- o_instr  output  BW_DATA  encoded instruction
- o_err  output  1  result carries an encoding error
- o_err_code  output  2  0 none, 1 out of range, 2 misaligned, 3 unknown format
- o_cnt_ok  output  BW_CNT  count of error-free results accepted downstream
- o_cnt_err  output  BW_CNT  count of errored results accepted downstream

## Operation
- Two-stage elastic pipeline: S1 (check), S2 (pack/output). Each stage has a valid bit; stage ready = !valid | next-stage ready. o_ready = S1 ready. i_ready feeds S2.
- S1 registers i_imm, i_imm_src and i_instr_base on input handshake (i_valid & o_ready). It also registers the check result:
  - I, S: range −2048..2047, otherwise code 1.
  - B: range −4096..4094, otherwise code 1; imm[0]≠0 gives code 2.
  - J: range −1048576..1048574, otherwise code 1; imm[0]≠0 gives code 2.
  - U: imm[11:0]≠0 gives code 2; every 32-bit value is in range.
  - Any other i_imm_src value gives code 3.
  - Range is checked before alignment: if both fail, code 1 is reported.
- S2 packing. Immediate bit positions are first cleared from the base word; all other bits come from base unchanged.
  - I: [31:20]=imm[11:0]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
  - U: [31:12]=imm[31:12]
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
- On error: o_instr = i_instr_base unmodified, o_err=1, o_err_code set.
- Counters increment on output handshake (o_valid & i_ready), o_cnt_ok or o_cnt_err according to o_err. Both wrap modulo 2^BW_CNT.
- Outputs o_instr/o_err/o_err_code stay stable while o_valid & !i_ready.

## Timing
- Reset (async assert, sync deassert use): S1/S2 valid=0, o_valid=0, o_instr=0, o_err=0, o_err_code=0, counters=0. o_ready=1 in the first cycle after reset release.
- Latency: an input accepted at edge N gives o_valid=1 after edge N+1 (2 registered stages). Throughput is 1 per cycle with i_ready held high.
- Backpressure: with i_ready=0, at most 2 results are buffered. o_ready drops to 0 once both stages are full, and no input is lost or duplicated.
- Simultaneous output and input handshake in the same cycle with a full pipeline: both stages advance, with no bubble.
- Reset asserted mid-operation: in-flight entries are discarded immediately and counters are cleared.

## Test plan
- I-type: base 0x00000093, imm 0xFFFFFFFF, I -> o_instr 0xFFF00093, o_err 0, o_valid two edges after acceptance.
- S and B: base 0x0020A023, imm 8, S -> 0x0020A423. Base 0x00000063, imm −4, B -> 0xFE000EE3.
- J and U: base 0x000000EF, imm 0x800, J -> 0x001000EF. Base 0x00000037, imm 0x12345000, U -> 0x12345037.
- Errors: B imm 3 -> o_err 1, code 2, o_instr = base. I imm 2048 -> code 1. i_imm_src = unused code -> code 3. After these three, o_cnt_err=3 and o_cnt_ok unchanged.
- Backpressure: stream 5 requests while i_ready=0 for 4 cycles. o_ready must fall after 2 acceptances, and all 5 results must emerge in order with stable outputs while stalled. o_cnt_ok=5 at the end.
- Reset mid-stream: assert i_rstn=0 with 2 entries in flight. o_valid=0 and counters=0 immediately, and the next request after release encodes correctly.
